// File: rtl/multi_code_converter_if.sv
// Handshake bundle for multi_code_converter: input word channel and result channel.
// The converter is on the slave side and the producer/consumer is on the master side.
interface multi_code_converter_if #(parameter int DIGITS = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            mode;
  logic [4*DIGITS-1:0]   din;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   dout;
  logic                  err;

  modport master (
    output in_valid, mode, din, out_ready,
    input  in_ready, out_valid, dout, err
  );

  modport slave (
    input  in_valid, mode, din, out_ready,
    output in_ready, out_valid, dout, err
  );
endinterface

// File: rtl/multi_code_converter.sv
// Digit-serial 4-bit code converter (BCD<->XS3, bin<->Gray), one nibble per clock.
// Define CONV_ERR_EN to compile in illegal-code detection; otherwise err is tied to 0.
module multi_code_converter #(
    parameter int DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multi_code_converter_if.slave    bus,
    output logic [1:0]               dbg_state
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     lat_din;
    logic [1:0]       lat_mode;
    logic [W-1:0]     result;
    logic [W-1:0]     res_next;
    logic [W-1:0]     dout_q;
    logic [3:0]       cur;
    logic [3:0]       conv;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             last;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never waits on ready and, once raised, is held with its data
    // stable until that transfer edge.
    always_comb begin
        cur  = lat_din[4*int'(idx) +: 4];
        conv = cur;
        case (lat_mode)
            2'b00: conv = cur + 4'd3;
            2'b01: conv = cur - 4'd3;
            2'b10: conv = cur ^ {1'b0, cur[3:1]};
            2'b11: conv = {cur[3], ^cur[3:2], ^cur[3:1], ^cur[3:0]};
            default: conv = cur;
        endcase
        res_next = result;
        res_next[4*int'(idx) +: 4] = conv;
        last = (idx == IDX_W'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            idx         <= '0;
            lat_din     <= '0;
            lat_mode    <= 2'b00;
            result      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        lat_din    <= bus.din;
                        lat_mode   <= bus.mode;
                        idx        <= '0;
                        result     <= '0;
                        in_ready_q <= 1'b0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    result <= res_next;
                    if (last) begin
                        // Final digit goes straight into dout so the result appears with out_valid.
                        idx         <= '0;
                        dout_q      <= res_next;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign dbg_state     = state;

`ifdef CONV_ERR_EN
    logic bad;
    logic err_acc;
    logic err_q;

    always_comb begin
        bad = 1'b0;
        case (lat_mode)
            2'b00:   bad = (cur > 4'd9);
            2'b01:   bad = (cur < 4'd3) || (cur > 4'd12);
            default: bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == IDLE && bus.in_valid && in_ready_q) begin
            err_acc <= 1'b0;
        end else if (state == CONV) begin
            err_acc <= err_acc | bad;
            if (last) err_q <= err_acc | bad;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_multi_code_converter.sv
// Directed plus randomized bench for multi_code_converter against a nibble-level
// arithmetic reference model; expectations for err follow CONV_ERR_EN.
module tb_multi_code_converter;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;
  int n_checks;
  int n_fail;
  logic [W-1:0] exp_q[$];

  multi_code_converter_if #(.DIGITS(DIGITS)) bus ();

  multi_code_converter #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // reference model: returns {err, dout}
  function automatic logic [W:0] model(input logic [1:0] m, input logic [W-1:0] d);
    logic [W-1:0] r;
    logic e;
    int dig, o;
    r = '0;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = int'(d[4*i +: 4]);
      case (m)
        2'd0: begin o = (dig + 3) % 16;  if (dig > 9) e = 1'b1; end
        2'd1: begin o = (dig + 13) % 16; if (dig < 3 || dig > 12) e = 1'b1; end
        2'd2: o = dig ^ (dig / 2);
        default: o = dig ^ (dig / 2) ^ (dig / 4) ^ (dig / 8);
      endcase
      r[4*i +: 4] = 4'(o);
    end
`ifndef CONV_ERR_EN
    e = 1'b0;
`endif
    return {e, r};
  endfunction

  // driver: present one word and return just after its accept edge
  task automatic start_word(input logic [1:0] m, input logic [W-1:0] d);
    int waited;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
    bus.mode = m;
    bus.din = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din = W'($urandom);
    bus.mode = 2'($urandom);
  endtask

  // scoreboard side: latency, result, backpressure hold, single transfer
  task automatic finish_word(input string tag, input logic [1:0] m, input logic [W-1:0] d, input int hold);
    logic [W:0] ref_v;
    logic [W-1:0] exp_d;
    ref_v = model(m, d);
    exp_q.push_back(ref_v[W-1:0]);
    for (int i = 1; i <= DIGITS; i++) begin
      @(posedge clk); #1;
      if (i >= DIGITS - 1)
        check({tag, "_latency"}, {63'd0, bus.out_valid}, (i == DIGITS) ? 64'd1 : 64'd0);
    end
    exp_d = exp_q.pop_front();
    check({tag, "_dout"}, 64'(bus.dout), 64'(exp_d));
    check({tag, "_err"}, {63'd0, bus.err}, {63'd0, ref_v[W]});
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = ~bus.in_valid;
      bus.din = W'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {63'd0, bus.out_valid}, 64'd1);
      check({tag, "_hold_dout"}, 64'(bus.dout), 64'(exp_d));
      check({tag, "_hold_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_xfer_valid"}, {63'd0, bus.out_valid}, 64'd0);
    check({tag, "_xfer_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
    check({tag, "_dout_kept"}, 64'(bus.dout), 64'(exp_d));
    @(posedge clk); #1;
    check({tag, "_idle"}, {62'd0, dbg_state}, 64'd0);
  endtask

  task automatic run_word(input string tag, input logic [1:0] m, input logic [W-1:0] d, input int hold);
    start_word(m, d);
    finish_word(tag, m, d, hold);
  endtask

  initial begin
    int hi_cnt;
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode = 2'b00;
    bus.din = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_err", {63'd0, bus.err}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    run_word("bcd_xs3", 2'd0, 16'h1234, 0);
    run_word("xs3_bcd", 2'd1, 16'h4567, 0);
    run_word("xs3_bad", 2'd1, 16'h0010, 0);
    run_word("bcd_bad", 2'd0, 16'h9A05, 0);
    run_word("bin_gray", 2'd2, 16'h0F58, 0);
    run_word("gray_bin", 2'd3, 16'h087C, 0);
    check("gray_model", 64'(model(2'd3, 16'h087C)), 64'h0F58);
    run_word("backpress", 2'd0, 16'h0789, 3);

    // reset two cycles into CONV
    start_word(2'd1, 16'hC3C3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) hi_cnt++;
    end
    check("midrst_no_pulse", 64'(hi_cnt), 64'd0);
    check("midrst_dout", 64'(bus.dout), 64'd0);
    check("midrst_ready", {63'd0, bus.in_ready}, 64'd1);
    run_word("after_rst", 2'd0, 16'h0000, 0);
    check("after_rst_val", 64'(bus.dout), 64'h3333);

    // randomized words against the model
    for (int n = 0; n < 24; n++) begin
      logic [1:0] rm;
      logic [W-1:0] rd;
      rm = 2'($urandom_range(0, 3));
      rd = W'($urandom);
      run_word("rand", rm, rd, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multi_code_converter.md
# multi_code_converter

Digit-serial, parametrised 4-bit code converter for the week-6 arithmetic datapath. It accepts a packed word of `DIGITS` nibbles through a valid/ready handshake and converts one nibble per clock in one of four modes: BCD→excess-3, excess-3→BCD, binary→Gray, or Gray→binary. It flags invalid input codes and returns the converted word through a second valid/ready handshake. It sits between operand registers and the BCD adder/subtractor stages.

## Interface
- `DIGITS`, default 4: number of 4-bit digits per word; legal range 1..16.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `din`/`mode` are valid.
- `in_ready`  output  1  block can accept a word (high only in IDLE).
- `mode`  input  2  00 BCD→XS3, 01 XS3→BCD, 10 bin→Gray, 11 Gray→bin.
- `din`  input  4*DIGITS  packed input; digit 0 = bits [3:0].
- `out_valid`  output  1  `dout`/`err` are valid.
- `out_ready`  input  1  consumer accepts the result.
- `dout`  output  4*DIGITS  converted word.
- `err`  output  1  one or more input digits were illegal for `mode` (see Configuration).

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - CONV: converting.
  - DONE: `out_valid`=1.
- IDLE→CONV on `in_valid && in_ready`:
  - `din` and `mode` are latched into internal registers.
  - Digit index `idx` is set to 0, the result register is cleared, and the error accumulator is cleared.
- CONV, on every edge:
  - Digit `idx` of the latched word is converted and written to digit `idx` of the result register.
  - `idx` increments.
  - When `idx`==DIGITS-1, the FSM moves to DONE.
- DONE: `dout` and `err` are held stable. On `out_valid && out_ready` the FSM returns to IDLE.
- Per-digit functions, all 4-bit and wrapping modulo 16:
  - 00: d+3.
  - 01: d−3.
  - 10: g = d ^ (d>>1).
  - 11: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
- Illegal digits:
  - Mode 00: d>9.
  - Mode 01: d<3 or d>12.
  - Modes 10 and 11: never illegal.
  - An illegal digit is still converted by the wrapping rule. `err` is the OR over all digits of the word.
- `mode` and `din` changes after acceptance have no effect on the word in flight.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, `in_ready`=1, `out_valid`=0, `dout`=0, `err`=0, `idx`=0.
- Latency: accept at edge k. `out_valid` rises after edge k+DIGITS. For DIGITS=1: one CONV cycle, then DONE.
- `out_valid` and `dout` are registered, with no combinational path from inputs.
- `in_ready` is decoded from state only. It does not depend on `out_ready`.
- Throughput: one word per DIGITS+2 cycles at best, because the IDLE cycle is mandatory after each result transfer.
- Backpressure: while `out_ready`=0 in DONE, `out_valid`, `dout` and `err` hold indefinitely.
- Reset mid-CONV or mid-DONE: the word is discarded and no `out_valid` pulse is produced. After release the block is in IDLE with `in_ready`=1.
- `dout` holds its last value after the transfer until the next DONE. It is cleared only by reset.

## Configuration
- `CONV_ERR_EN` defined:
  - Illegal-code detection is compiled in.
  - `err` behaves as described above.
- `CONV_ERR_EN` undefined:
  - The detection logic and error accumulator are removed.
  - `err` is tied to 0.
  - Conversion results and timing are identical.

## Test plan
- DIGITS=4, mode 00, `din`=0x1234, `out_ready`=1 → `out_valid` rises 4 edges after accept; `dout`=0x4567, `err`=0; `in_ready` returns to 1 one cycle after the transfer.
- Mode 01, `din`=0x4567 → `dout`=0x1234, `err`=0. Then `din`=0x0010 → `dout`=0xDDED, `err`=1 with `CONV_ERR_EN`, 0 without.
- Mode 00, `din`=0x9A05 → `dout`=0xCD38; `err`=1 with `CONV_ERR_EN`, 0 without.
- Mode 10, `din`=0x0F58 → `dout`=0x087C. Mode 11, `din`=0x087C → `dout`=0x0F58. `err`=0 in both cases.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles in DONE, while toggling `in_valid` and changing `din` → `dout`/`out_valid` stay stable, `in_ready`=0 and no new word is accepted.
  - Raise `out_ready` → exactly one transfer, then IDLE.
- Reset mid-operation: drive `rst_n` low for 2 cycles, 2 cycles into CONV → `out_valid` never asserts, `dout`=0 and `in_ready`=1 after release. A following word 0x0000 in mode 00 → 0x3333.
